// File: rtl/gate_tt_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer: FSM state encoding
// and the reference truth tables for the 2-input gate family.
package gate_tt_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Bit i is the expected gate output for input vector i (A = MSB).
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    localparam int SETTLE_W = 4;

endpackage

// File: rtl/gate_tt_settle_cnt.sv
// Loadable down-counter with a zero flag; times the settle interval between
// an input change and the sample of the gate output.
module gate_tt_settle_cnt
    import gate_tt_sequencer_pkg::*;
#(
    parameter int W = SETTLE_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Sweeps a combinational gate through every input combination, samples its
// output after a settle delay and compares it against an expected truth table.
module gate_tt_sequencer
    import gate_tt_sequencer_pkg::*;
#(
    parameter int                    N_IN   = 2,
    parameter int                    SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]  EXPECT = TT_NAND
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [N_IN-1:0]        in_vec,
    input  logic                   y_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   mismatch,
    output logic [N_IN:0]          err_count
);

    localparam logic [N_IN-1:0]     LAST_VEC    = {N_IN{1'b1}};
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE - 1);

    state_e                 state_q;
    logic [N_IN-1:0]        in_vec_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic [(1<<N_IN)-1:0]   mismatch_q;
    logic [N_IN:0]          err_q;
    logic [N_IN:0]          err_d;
    logic                   miss_s;
    logic                   last_s;
    logic                   cnt_load_s;
    logic                   cnt_dec_s;
    logic                   cnt_zero_s;

    // Compare result, running error count and settle-counter controls.
    always_comb begin
        miss_s     = (y_in != EXPECT[in_vec_q]);
        err_d      = err_q + {{N_IN{1'b0}}, miss_s};
        last_s     = (in_vec_q == LAST_VEC);
        cnt_load_s = ((state_q == ST_IDLE) && start) ||
                     ((state_q == ST_SAMPLE) && !last_s);
        cnt_dec_s  = (state_q == ST_SETTLE);
    end

    gate_tt_settle_cnt #(.W(SETTLE_W)) u_settle_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (cnt_load_s),
        .load_val_i (SETTLE_INIT),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s)
    );

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_vec_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= '0;
            err_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mismatch_q <= '0;
                        err_q      <= '0;
                        pass_q     <= 1'b0;
                        in_vec_q   <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SETTLE;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero_s) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SAMPLE: begin
                    if (miss_s) begin
                        mismatch_q[in_vec_q] <= 1'b1;
                    end
                    err_q <= err_d;
                    if (last_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                        state_q <= ST_DONE;
                    end else begin
                        in_vec_q <= in_vec_q + 1'b1;
                        state_q  <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_vec    = in_vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign mismatch  = mismatch_q;
    assign err_count = err_q;

endmodule

// File: doc/gate_tt_sequencer.md
Name: gate_tt_sequencer

Overview:
Clocked truth-table sequencer for the combinational gate blocks (NAND and siblings). Sits directly upstream of the gate under test and drives its input vector through all 2^N_IN combinations. It also consumes the gate output, samples it after a settle interval, and compares it against an expected truth table. It produces a per-combination mismatch mask and a pass/fail verdict, replacing hand-timed stimulus with a reusable synthesizable stage.

Parameters:
N_IN, 2, number of gate inputs; combinations = 2^N_IN (legal 1..4)
SETTLE, 2, clock cycles between input change and sampling of y_in (legal 1..15)
EXPECT, 4'b0111, expected output per combination; bit i = expected y for input vector i (default = 2-input NAND)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a sweep; sampled only in IDLE
in_vec  output  N_IN  drive to gate inputs; in_vec[N_IN-1] = A (MSB), in_vec[0] = B for N_IN=2
y_in  input  1  gate output under test
busy  output  1  high from the cycle after start is accepted until DONE
done  output  1  single-cycle pulse when sweep completes
pass  output  1  valid from the done pulse until the next start; 1 = no mismatches
mismatch  output  2^N_IN  bit i set if the sample for vector i differed from EXPECT[i]
err_count  output  N_IN+1  number of mismatching combinations

Behaviour:
- Reset (async, immediate) values: state=IDLE, in_vec=0, busy=0, done=0, pass=0, mismatch=0, err_count=0, settle counter=0.
- Single clock domain. All outputs are registered. y_in is sampled synchronously; there is no synchroniser, because y_in is a combinational function of in_vec.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 -> clear mismatch and err_count, set in_vec=0, settle counter=SETTLE-1, busy=1, go to SETTLE. start=0 -> stay in IDLE.
- SETTLE: decrement the counter each cycle; at 0 go to SAMPLE. Time from in_vec change to sample is exactly SETTLE cycles.
- SAMPLE (1 cycle): compare y_in with EXPECT[in_vec].
  - On mismatch, set mismatch[in_vec] and increment err_count.
  - If in_vec = 2^N_IN-1, go to DONE.
  - Otherwise increment in_vec, reload the counter to SETTLE-1, and go to SETTLE.
- DONE (1 cycle): done=1, busy=0, pass=(err_count==0 after the final compare, i.e. the next-state value), go to IDLE. in_vec holds its last value, and mismatch/err_count/pass hold until the next accepted start.
- Sweep latency: start accepted at cycle 0 -> done pulse at cycle 2^N_IN*(SETTLE+1)+1. For defaults this is 13.
- start asserted while busy is ignored. start held high continuously re-triggers in the IDLE cycle following DONE. This makes back-to-back sweeps possible, with one IDLE cycle between them.
- Arithmetic: in_vec wraps only by explicit reset to 0 on a new start; it never increments past 2^N_IN-1. err_count cannot overflow, because it is sized N_IN+1 bits for a maximum of 2^N_IN.
- X on y_in in SAMPLE is counted as a mismatch (compare uses !==-equivalent semantics in the bench model; RTL compares with ==, and the bench must not drive X).
- rst asserted mid-sweep aborts immediately to reset values. No done pulse is produced.

Decomposition:
- Shared package holds:
  - the state encoding typedef (IDLE/SETTLE/SAMPLE/DONE);
  - the NAND/AND/OR/NOR/XOR truth-table constants for N_IN=2 (4'b0111, 4'b1000, 4'b1110, 4'b0001, 4'b0110), reused as EXPECT values.
- One natural sub-module: gate_tt_settle_cnt, a loadable down-counter with a zero flag. Everything else stays in the top.

Test Plan:
- Defaults, gate_nand connected, pulse start -> in_vec steps 00,01,10,11 at cycles 1,4,7,10; done pulses at cycle 13; pass=1, mismatch=4'b0000, err_count=0.
- Defaults, gate replaced by an AND model -> pass=0, mismatch=4'b1111, err_count=4.
- Defaults, y_in tied to 1 -> mismatch=4'b1000, err_count=1, pass=0.
- SETTLE=5, NAND -> done at cycle 4*6+1=25. Also inject y_in correct only after 3 cycles of each vector -> still pass=1.
- Assert rst at cycle 6 of a sweep -> all outputs 0 the same cycle, no done pulse. A new start after release gives a clean pass=1.
- start held high for 30 cycles, NAND -> two consecutive sweeps, done pulses at cycles 13 and 27; start pulses while busy are ignored.
